// File: rtl/overlapping_seq_detector_pkg.sv
// Purpose : shared widths, default pattern and nibble type for the overlapping sequence detector.
// Latency : n/a (declarations only).
// Backpr. : n/a.
package overlapping_seq_pkg;

  localparam int NIBBLE_W = 4;
  localparam int HIST_W   = 3;
  // Window seen each cycle: previous nibble's last three bits plus the current nibble.
  localparam int WIN_W    = HIST_W + NIBBLE_W;

  typedef logic [NIBBLE_W-1:0] nibble_t;

  localparam nibble_t DEFAULT_PATTERN = 4'b1011;

endpackage

// File: rtl/overlapping_seq_detector_if.sv
// Purpose : bundles the nibble stream input and the detector status outputs.
// Latency : n/a (wiring only).
// Backpr. : none; one nibble per clock.
// Ports   : data_in (stream nibble, bit 3 oldest), detected, match_vec, match_count.
//           master = stream source / status consumer, slave = detector.
interface overlapping_seq_detector_if
  import overlapping_seq_pkg::*;
#(
  parameter int COUNT_W = 8
);

  nibble_t              data_in;
  logic                 detected;
  nibble_t              match_vec;
  logic [COUNT_W-1:0]   match_count;

  modport master (
    output data_in,
    input  detected,
    input  match_vec,
    input  match_count
  );

  modport slave (
    input  data_in,
    output detected,
    output match_vec,
    output match_count
  );

endinterface

// File: rtl/overlapping_seq_detector_window_match.sv
// Purpose : compares the pattern against every 4-bit slice of the 7-bit window.
// Latency : combinational.
// Backpr. : none.
// Ports   : window (bit 6 oldest), hist_ok (history valid), match (bit k = pattern ends at window[k]).
module seq_window_match
  import overlapping_seq_pkg::*;
#(
  parameter nibble_t PATTERN = DEFAULT_PATTERN
) (
  input  logic [WIN_W-1:0] window,
  input  logic             hist_ok,
  output nibble_t          match
);

  always_comb begin
    match = '0;
    for (int k = 0; k < NIBBLE_W; k++) begin
      // Offsets above 0 reach into history bits; after reset those are zeros
      // that never came from the stream, so they must not produce matches.
      match[k] = (window[k +: NIBBLE_W] == PATTERN) && ((k == 0) || hist_ok);
    end
  end

endmodule

// File: rtl/overlapping_seq_detector.sv
// Purpose : flags every (overlapping, nibble-straddling) occurrence of PATTERN in a nibble stream.
// Latency : 1 cycle; outputs describe the nibble sampled at the most recent edge.
// Backpr. : none; a nibble is consumed on every rising edge.
// Ports   : clk, reset (async, active high), bus (slave: data_in in; detected, match_vec,
//           saturating match_count out).
module overlapping_seq_detector
  import overlapping_seq_pkg::*;
#(
  parameter nibble_t PATTERN = DEFAULT_PATTERN,
  parameter int      COUNT_W = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  overlapping_seq_detector_if.slave     bus
);

  localparam int SUM_W = COUNT_W + 3;
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  logic [HIST_W-1:0]  hist;
  logic               hist_ok;
  logic               detected_q;
  nibble_t            match_vec_q;
  logic [COUNT_W-1:0] count_q;

  logic [WIN_W-1:0]   window;
  nibble_t            match;
  logic [2:0]         pop;
  logic [SUM_W-1:0]   sum;
  logic [COUNT_W-1:0] count_nxt;

  assign window = {hist, bus.data_in};

  seq_window_match #(
    .PATTERN (PATTERN)
  ) u_match (
    .window  (window),
    .hist_ok (hist_ok),
    .match   (match)
  );

  always_comb begin
    pop = '0;
    for (int k = 0; k < NIBBLE_W; k++) begin
      pop = pop + {2'b00, match[k]};
    end
  end

  // Widened sum so a multi-match nibble near the top cannot wrap before clamping.
  always_comb begin
    sum       = {3'b000, count_q} + SUM_W'(pop);
    count_nxt = (sum > {3'b000, CNT_MAX}) ? CNT_MAX : sum[COUNT_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist        <= '0;
      hist_ok     <= 1'b0;
      detected_q  <= 1'b0;
      match_vec_q <= '0;
      count_q     <= '0;
    end else begin
      hist        <= bus.data_in[HIST_W-1:0];
      hist_ok     <= 1'b1;
      detected_q  <= |match;
      match_vec_q <= match;
      count_q     <= count_nxt;
    end
  end

  assign bus.detected    = detected_q;
  assign bus.match_vec   = match_vec_q;
  assign bus.match_count = count_q;

endmodule

// File: tb/tb_overlapping_seq_detector.sv
// Purpose : directed table-driven bench for overlapping_seq_detector.
// Latency : outputs sampled 1 time unit after the rising edge that consumed each nibble.
// Backpr. : n/a.
module tb_overlapping_seq_detector;
  import overlapping_seq_pkg::*;

  logic    clk;
  logic    reset;
  nibble_t data_in;

  int tests;
  int fails;

  overlapping_seq_detector_if #(.COUNT_W(8)) bus1 ();
  overlapping_seq_detector_if #(.COUNT_W(8)) bus2 ();

  assign bus1.data_in = data_in;
  assign bus2.data_in = data_in;

  overlapping_seq_detector #(.PATTERN(4'b1011), .COUNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  // Second instance exercises the all-zero-history false-match case.
  overlapping_seq_detector #(.PATTERN(4'b0001), .COUNT_W(8)) dut_zero (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    nibble_t    din;
    logic       det;
    nibble_t    mv;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[10];

  task automatic apply(input nibble_t din);
    @(negedge clk);
    reset   = 1'b0;
    data_in = din;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic det, input nibble_t mv, input logic [7:0] cnt);
    tests++;
    if (bus1.detected !== det || bus1.match_vec !== mv || bus1.match_count !== cnt) begin
      fails++;
      $display("FAIL %s: got det=%b mv=%b cnt=%0d, want det=%b mv=%b cnt=%0d",
               name, bus1.detected, bus1.match_vec, bus1.match_count, det, mv, cnt);
    end
  endtask

  initial begin
    logic [7:0] exp_cnt;
    tests   = 0;
    fails   = 0;
    reset   = 1'b1;
    data_in = '0;

    tbl[0] = '{4'b1011, 1'b1, 4'b0001, 8'd1};  // plain match, no history yet
    tbl[1] = '{4'b1101, 1'b0, 4'b0000, 8'd1};  // window 0111101
    tbl[2] = '{4'b0101, 1'b0, 4'b0000, 8'd1};
    tbl[3] = '{4'b1000, 1'b1, 4'b1000, 8'd2};  // straddle: window 1011000
    tbl[4] = '{4'b0101, 1'b0, 4'b0000, 8'd2};
    tbl[5] = '{4'b1011, 1'b1, 4'b1001, 8'd4};  // overlap: window 1011011
    tbl[6] = '{4'b0110, 1'b1, 4'b0010, 8'd5};  // window 0110110
    tbl[7] = '{4'b1101, 1'b1, 4'b0100, 8'd6};  // window 1101101
    tbl[8] = '{4'b1111, 1'b1, 4'b1000, 8'd7};  // window 1011111
    tbl[9] = '{4'b0110, 1'b1, 4'b0010, 8'd8};  // window 1110110

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 1'b0, 4'b0000, 8'd0);

    for (int i = 0; i < 10; i++) begin
      apply(tbl[i].din);
      check($sformatf("vec%0d", i), tbl[i].det, tbl[i].mv, tbl[i].cnt);
    end

    // Reset mid-stream: the 0101 half of a straddled pattern must be forgotten.
    apply(4'b1011);
    check("pre_reset_match", 1'b1, 4'b0001, 8'd9);
    apply(4'b0101);
    check("pre_reset_nomatch", 1'b0, 4'b0000, 8'd9);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_clear", 1'b0, 4'b0000, 8'd0);
    apply(4'b1000);
    check("no_straddle_after_reset", 1'b0, 4'b0000, 8'd0);
    tests++;
    if (bus2.detected !== 1'b0 || bus2.match_vec !== 4'b0000) begin
      fails++;
      $display("FAIL zero_hist_pattern0001: got det=%b mv=%b, want det=0 mv=0000",
               bus2.detected, bus2.match_vec);
    end

    // Saturation: one match per nibble, counter must clamp at 255.
    exp_cnt = 8'd0;
    for (int i = 0; i < 260; i++) begin
      apply(4'b1011);
      exp_cnt = (exp_cnt == 8'd255) ? 8'd255 : exp_cnt + 8'd1;
      check($sformatf("sat%0d", i), 1'b1, 4'b0001, exp_cnt);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
